// File: rtl/sfx_request_arbiter.sv
// ---------------------------------------------------------------------------
// sfx_request_arbiter
//
// Initiator side of the sound-effect trigger interface. Raw game-event levels
// are edge-detected into latched requests. Requests are arbitrated by fixed
// priority, where the highest index wins. Each grant sends one single-cycle
// start pulse to the matching tone-generator channel. The tone generators
// give no busy indication, so this block times each effect's play window
// itself. A short forced silence follows every completed effect.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   ev_in        raw event levels from game logic, synchronous to clk
//   mute         level; aborts play and discards all requests while high
//   start_pulse  one-hot, one-cycle trigger to the tone generator enables
//   active       one-hot level; the effect currently inside its play window
//   pending      latched requests that have not been granted yet
//   busy         high while playing or in the post-effect gap
// ---------------------------------------------------------------------------
module sfx_request_arbiter #(
    parameter int NUM_EV     = 4,
    parameter int DUR_CYCLES = 12500000,
    parameter int GAP_CYCLES = 25000,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_EV-1:0] ev_in,
    input  logic              mute,
    output logic [NUM_EV-1:0] start_pulse,
    output logic [NUM_EV-1:0] active,
    output logic [NUM_EV-1:0] pending,
    output logic              busy
);

    localparam int IDX_W = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;
    localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DUR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t            state;
    logic [NUM_EV-1:0] prev_ev;
    logic [CNT_W-1:0]  timer;
    logic [IDX_W-1:0]  act_idx;

    logic [NUM_EV-1:0] rise;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_pending;
    logic              do_grant;
    logic [NUM_EV-1:0] grant_mask;

    // Rising-edge detection and fixed-priority selection of the highest
    // pending index. The loop runs upward, so the last match is the top one.
    always_comb begin
        rise        = ev_in & ~prev_ev;
        any_pending = |pending;
        grant_idx   = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            if (pending[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Decide whether a grant happens this cycle. In PLAY only a strictly
    // higher request may preempt. A preemption is held off for one cycle
    // right after a pulse, so start_pulse can never be high two cycles in a
    // row. That case needs a higher rise landing on the grant edge itself.
    always_comb begin
        do_grant = 1'b0;
        if (!mute) begin
            case (state)
                IDLE:    do_grant = any_pending;
                PLAY:    do_grant = any_pending && (grant_idx > act_idx) &&
                                    !(|start_pulse);
                default: do_grant = 1'b0;
            endcase
        end
        grant_mask = do_grant ? (NUM_EV'(1) << grant_idx) : '0;
    end

    assign busy = (state != IDLE);

    // Main sequencer. Mute overrides everything except reset. A rise that
    // coincides with the grant of the same index re-sets the pending bit,
    // so the effect plays once more after the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_ev     <= ev_in;
            timer       <= '0;
            act_idx     <= '0;
            start_pulse <= '0;
            active      <= '0;
            pending     <= '0;
        end else begin
            prev_ev     <= ev_in;
            start_pulse <= '0;
            if (mute) begin
                pending <= '0;
                active  <= '0;
                timer   <= '0;
                state   <= IDLE;
            end else begin
                pending <= (pending & ~grant_mask) | rise;
                case (state)
                    IDLE: begin
                        if (do_grant) begin
                            start_pulse <= grant_mask;
                            active      <= grant_mask;
                            act_idx     <= grant_idx;
                            timer       <= '0;
                            state       <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (do_grant) begin
                            start_pulse <= grant_mask;
                            active      <= grant_mask;
                            act_idx     <= grant_idx;
                            timer       <= '0;
                        end else if (timer == DUR_LAST) begin
                            active <= '0;
                            timer  <= '0;
                            state  <= GAP;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (timer == GAP_LAST) begin
                            timer <= '0;
                            state <= IDLE;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        timer <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfx_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sfx_request_arbiter
//
// Scenario bench for sfx_request_arbiter, built with a short play window of
// 8 cycles and a gap of 2 cycles. Each scenario task queues the start pulses
// it expects, as (cycle, value) pairs. The pulse monitor pops and compares
// them whenever the DUT pulses. Level outputs are checked inline at chosen
// cycles. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sfx_request_arbiter;

    localparam int NUM_EV = 4;
    localparam int DUR    = 8;
    localparam int GAP    = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_EV-1:0] ev_in;
    logic              mute;
    logic [NUM_EV-1:0] start_pulse;
    logic [NUM_EV-1:0] active;
    logic [NUM_EV-1:0] pending;
    logic              busy;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } pulse_t;

    pulse_t     exp_q[$];
    pulse_t     mon_e;
    logic [3:0] last_pulse = 4'b0;

    sfx_request_arbiter #(
        .NUM_EV    (NUM_EV),
        .DUR_CYCLES(DUR),
        .GAP_CYCLES(GAP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_in      (ev_in),
        .mute       (mute),
        .start_pulse(start_pulse),
        .active     (active),
        .pending    (pending),
        .busy       (busy)
    );

    // Free-running clock and a count of rising edges used as the cycle index.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Pulse monitor: every observed start pulse must match the next expected
    // entry in value and cycle. It must also be one-hot and must not follow
    // another pulse directly.
    always @(negedge clk) begin
        if (start_pulse !== 4'b0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pulse: got %b at cycle %0d, required none", start_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (start_pulse !== mon_e.val || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("[TB] FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", start_pulse, cyc, mon_e.val, mon_e.cyc);
                end
            end
            vectors++;
            if (!$onehot(start_pulse) || last_pulse !== 4'b0) begin
                miscompares++;
                $display("[TB] FAIL pulse_shape: got %b after %b, required one-hot after 0000", start_pulse, last_pulse);
            end
        end
        last_pulse = start_pulse;
    end

    // Advance to the falling edge that follows rising edge number t.
    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        int c;
        wait_to(3);
        vectors++;
        if (start_pulse !== 4'b0 || active !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pulse_active: got %b/%b, required 0000/0000", start_pulse, active);
        end
        vectors++;
        if (pending !== 4'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pending_busy: got %b/%b, required 0000/0", pending, busy);
        end
        c = cyc;
        reset = 1'b0;
        wait_to(c + 2);
        vectors++;
        if (pending !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_exit_pending: got %b, required 0000", pending);
        end
        wait_to(c + 14);
        ev_in = 4'b0000;
        wait_to(c + 17);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_single();
        int c;
        c = cyc;
        ev_in = 4'b0001;
        exp_q.push_back('{c + 2, 4'b0001});
        wait_to(c + 1);
        vectors++;
        if (pending !== 4'b0001 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_pending: got %b/%b, required 0001/0", pending, busy);
        end
        wait_to(c + 2);
        vectors++;
        if (active !== 4'b0001 || pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_active_start: got %b/%b, required 0001/0000", active, pending);
        end
        wait_to(c + 9);
        vectors++;
        if (active !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_active_end: got %b, required 0001", active);
        end
        wait_to(c + 10);
        vectors++;
        if (active !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_gap: got %b/%b, required 0000/1", active, busy);
        end
        wait_to(c + 11);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_gap_busy: got %b, required 1", busy);
        end
        wait_to(c + 12);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: got %b, required 0", busy);
        end
        ev_in = 4'b0000;
        wait_to(c + 16);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL single_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        int c;
        c = cyc;
        ev_in = 4'b1010;
        exp_q.push_back('{c + 2, 4'b1000});
        exp_q.push_back('{c + 13, 4'b0010});
        wait_to(c + 1);
        vectors++;
        if (pending !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL simul_pending: got %b, required 1010", pending);
        end
        wait_to(c + 2);
        vectors++;
        if (pending !== 4'b0010 || active !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL simul_first: got %b/%b, required 0010/1000", pending, active);
        end
        ev_in = 4'b0000;
        wait_to(c + 13);
        vectors++;
        if (pending !== 4'b0000 || active !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL simul_second: got %b/%b, required 0000/0010", pending, active);
        end
        wait_to(c + 27);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL simul_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_preempt();
        int c;
        c = cyc;
        ev_in = 4'b0001;
        exp_q.push_back('{c + 2, 4'b0001});
        exp_q.push_back('{c + 7, 4'b0100});
        wait_to(c + 5);
        ev_in = 4'b0101;
        wait_to(c + 7);
        vectors++;
        if (active !== 4'b0100 || pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL preempt_active: got %b/%b, required 0100/0000", active, pending);
        end
        ev_in = 4'b0000;
        wait_to(c + 14);
        vectors++;
        if (active !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL preempt_restart: got %b, required 0100", active);
        end
        wait_to(c + 15);
        vectors++;
        if (active !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL preempt_gap: got %b/%b, required 0000/1", active, busy);
        end
        wait_to(c + 30);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL preempt_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_merge();
        int c;
        c = cyc;
        ev_in = 4'b0010;
        exp_q.push_back('{c + 2, 4'b0010});
        exp_q.push_back('{c + 13, 4'b0010});
        for (int k = 3; k <= 8; k++) begin
            wait_to(c + k);
            ev_in = (k % 2 == 0) ? 4'b0010 : 4'b0000;
        end
        wait_to(c + 9);
        vectors++;
        if (pending !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL merge_pending: got %b, required 0010", pending);
        end
        ev_in = 4'b0000;
        wait_to(c + 13);
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL merge_cleared: got %b, required 0000", pending);
        end
        wait_to(c + 30);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL merge_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int c;
        c = cyc;
        ev_in = 4'b0001;
        exp_q.push_back('{c + 2, 4'b0001});
        exp_q.push_back('{c + 13, 4'b0001});
        exp_q.push_back('{c + 24, 4'b0001});
        wait_to(c + 3);
        ev_in = 4'b0000;
        wait_to(c + 4);
        ev_in = 4'b0001;
        wait_to(c + 11);
        ev_in = 4'b0000;
        wait_to(c + 12);
        ev_in = 4'b0001;
        wait_to(c + 13);
        vectors++;
        if (pending !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL b2b_set_wins: got %b, required 0001", pending);
        end
        ev_in = 4'b0000;
        wait_to(c + 24);
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_cleared: got %b, required 0000", pending);
        end
        wait_to(c + 38);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mute();
        int c;
        c = cyc;
        ev_in = 4'b1000;
        exp_q.push_back('{c + 2, 4'b1000});
        wait_to(c + 3);
        ev_in = 4'b1100;
        wait_to(c + 6);
        vectors++;
        if (pending !== 4'b0100 || active !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL mute_setup: got %b/%b, required 0100/1000", pending, active);
        end
        mute = 1'b1;
        wait_to(c + 7);
        vectors++;
        if (active !== 4'b0000 || pending !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mute_abort: got %b/%b/%b, required 0000/0000/0", active, pending, busy);
        end
        ev_in = 4'b1101;
        wait_to(c + 10);
        mute = 1'b0;
        wait_to(c + 11);
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL mute_discard: got %b, required 0000", pending);
        end
        wait_to(c + 24);
        ev_in = 4'b0000;
        wait_to(c + 26);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL mute_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midplay();
        int c;
        c = cyc;
        ev_in = 4'b0100;
        exp_q.push_back('{c + 2, 4'b0100});
        wait_to(c + 3);
        ev_in = 4'b0110;
        wait_to(c + 4);
        vectors++;
        if (pending !== 4'b0010 || active !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL rstmid_setup: got %b/%b, required 0010/0100", pending, active);
        end
        reset = 1'b1;
        wait_to(c + 5);
        vectors++;
        if (active !== 4'b0000 || pending !== 4'b0000 || busy !== 1'b0 || start_pulse !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rstmid_clear: got %b/%b/%b/%b, required 0000/0000/0/0000", active, pending, busy, start_pulse);
        end
        wait_to(c + 6);
        reset = 1'b0;
        wait_to(c + 20);
        ev_in = 4'b0000;
        wait_to(c + 22);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_missing: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scenario sequence; reset is held from time zero with every event high.
    initial begin
        reset = 1'b1;
        ev_in = 4'b1111;
        mute  = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_preempt();
        test_merge();
        test_back_to_back();
        test_mute();
        test_reset_midplay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
